// File: rtl/lfsr_descramble_sync.sv
// Lock/resync controller around a self-synchronising LFSR descrambler: resets and flushes it,
// hunts for lock on the descrambled idle pattern, then watches the error rate to detect loss of lock.
module lfsr_descramble_sync #(
  parameter int                    DATA_WIDTH    = 8,
  parameter int                    LFSR_WIDTH    = 58,
  parameter int                    DESC_LATENCY  = 1,
  parameter logic [DATA_WIDTH-1:0] IDLE_PATTERN  = '0,
  parameter int                    LOCK_COUNT    = 16,
  parameter int                    HUNT_TIMEOUT  = 1024,
  parameter int                    ERR_WINDOW    = 64,
  parameter int                    UNLOCK_ERRORS = 4
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic [DATA_WIDTH-1:0] in_data,
  input  logic                  in_valid,
  input  logic                  resync,
  input  logic                  err_in,
  output logic                  desc_rst,
  output logic [DATA_WIDTH-1:0] desc_data_in,
  output logic                  desc_data_in_valid,
  input  logic [DATA_WIDTH-1:0] desc_data_out,
  output logic                  locked,
  output logic                  lock_lost,
  output logic [15:0]           err_count,
  output logic [1:0]            state_dbg
);

  localparam int FLUSH_WORDS = (LFSR_WIDTH + DATA_WIDTH - 1) / DATA_WIDTH;
  localparam int FW_W = $clog2(FLUSH_WORDS + 1);
  localparam int MT_W = $clog2(LOCK_COUNT + 1);
  localparam int HT_W = $clog2(HUNT_TIMEOUT + 1);
  localparam int WN_W = $clog2(ERR_WINDOW + 1);
  localparam int WE_W = $clog2(UNLOCK_ERRORS + 1);

  localparam logic [FW_W-1:0] FLUSH_LAST  = FW_W'(FLUSH_WORDS - 1);
  localparam logic [MT_W-1:0] LOCK_MAX    = MT_W'(LOCK_COUNT);
  localparam logic [HT_W-1:0] HUNT_MAX    = HT_W'(HUNT_TIMEOUT);
  localparam logic [WN_W-1:0] WIN_LAST    = WN_W'(ERR_WINDOW - 1);
  localparam logic [WE_W-1:0] UNLOCK_MAX  = WE_W'(UNLOCK_ERRORS);

  typedef enum logic [1:0] {
    ST_RESYNC = 2'd0,
    ST_FLUSH  = 2'd1,
    ST_HUNT   = 2'd2,
    ST_LOCKED = 2'd3
  } state_t;

  state_t          state, next_state;
  logic            rs_cnt, rs_cnt_n;
  logic [FW_W-1:0] flush_cnt, flush_n;
  logic [MT_W-1:0] match_cnt, match_n;
  logic [HT_W-1:0] hunt_cnt, hunt_n;
  logic [WN_W-1:0] win_cnt, win_n;
  logic [WE_W-1:0] werr_cnt, werr_n;
  logic            err_hit;
  logic            out_valid;

  // in_valid qualifies in_data on every cycle; there is no backpressure, words arriving
  // while the descrambler is held in reset are dropped.
  assign desc_data_in       = in_data;
  assign desc_data_in_valid = in_valid & ~desc_rst;
  assign state_dbg          = state;

  // out_valid marks the cycle the descrambler presents the word matching an accepted input.
  generate
    if (DESC_LATENCY == 0) begin : g_lat0
      assign out_valid = desc_data_in_valid;
    end else if (DESC_LATENCY == 1) begin : g_lat1
      logic vpipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          vpipe <= 1'b0;
        else if (desc_rst) vpipe <= 1'b0;
        else               vpipe <= desc_data_in_valid;
      end
      assign out_valid = vpipe;
    end else begin : g_latn
      logic [DESC_LATENCY-1:0] vpipe;
      always_ff @(posedge clk or negedge rst) begin
        if (!rst)          vpipe <= '0;
        else if (desc_rst) vpipe <= '0;
        else               vpipe <= {vpipe[DESC_LATENCY-2:0], desc_data_in_valid};
      end
      assign out_valid = vpipe[DESC_LATENCY-1];
    end
  endgenerate

  always_comb begin
    next_state = state;
    rs_cnt_n   = rs_cnt;
    flush_n    = flush_cnt;
    match_n    = match_cnt;
    hunt_n     = hunt_cnt;
    win_n      = win_cnt;
    werr_n     = werr_cnt;
    err_hit    = 1'b0;
    case (state)
      ST_RESYNC: begin
        rs_cnt_n = 1'b1;
        if (rs_cnt) next_state = ST_FLUSH;
      end
      ST_FLUSH: begin
        if (out_valid) begin
          if (flush_cnt == FLUSH_LAST) begin
            flush_n    = '0;
            next_state = ST_HUNT;
          end else begin
            flush_n = flush_cnt + 1'b1;
          end
        end
      end
      ST_HUNT: begin
        if (out_valid) begin
          hunt_n = hunt_cnt + 1'b1;
          if (desc_data_out == IDLE_PATTERN) match_n = match_cnt + 1'b1;
          else                               match_n = '0;
          // Lock wins over the timeout when both land on the same word.
          if (match_n == LOCK_MAX)     next_state = ST_LOCKED;
          else if (hunt_n == HUNT_MAX) next_state = ST_RESYNC;
        end
      end
      ST_LOCKED: begin
        if (out_valid) begin
          err_hit = err_in;
          if (win_cnt == WIN_LAST) begin
            win_n  = '0;
            werr_n = WE_W'(err_in);
          end else begin
            win_n  = win_cnt + 1'b1;
            werr_n = werr_cnt + WE_W'(err_in);
          end
          if (werr_n == UNLOCK_MAX) next_state = ST_RESYNC;
        end
      end
      default: next_state = ST_RESYNC;
    endcase
    if (resync) next_state = ST_RESYNC;
    // Entering (or re-entering) RESYNC restarts the reset pulse and clears the hunt/window bookkeeping.
    if (next_state == ST_RESYNC && (state != ST_RESYNC || resync)) begin
      rs_cnt_n  = 1'b0;
      flush_n   = '0;
      match_n   = '0;
      hunt_n    = '0;
      win_n     = '0;
      werr_n    = '0;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state     <= ST_RESYNC;
      rs_cnt    <= 1'b0;
      flush_cnt <= '0;
      match_cnt <= '0;
      hunt_cnt  <= '0;
      win_cnt   <= '0;
      werr_cnt  <= '0;
      desc_rst  <= 1'b1;
      locked    <= 1'b0;
      lock_lost <= 1'b0;
      err_count <= '0;
    end else begin
      state     <= next_state;
      rs_cnt    <= rs_cnt_n;
      flush_cnt <= flush_n;
      match_cnt <= match_n;
      hunt_cnt  <= hunt_n;
      win_cnt   <= win_n;
      werr_cnt  <= werr_n;
      desc_rst  <= (next_state == ST_RESYNC);
      locked    <= (next_state == ST_LOCKED);
      lock_lost <= (state == ST_LOCKED) && (next_state == ST_RESYNC);
      if (err_hit && err_count != 16'hFFFF) err_count <= err_count + 16'd1;
    end
  end

endmodule

// File: tb/tb_lfsr_descramble_sync.sv
// Bench for lfsr_descramble_sync: a one-cycle identity descrambler stub, a word-level reference
// model feeding an expected-status queue, and a negedge monitor comparing DUT status against it.
module tb_lfsr_descramble_sync;

  localparam int          DW            = 8;
  localparam logic [7:0]  IDLE          = 8'h00;
  localparam int          LOCK_COUNT    = 16;
  localparam int          HUNT_TIMEOUT  = 1024;
  localparam int          ERR_WINDOW    = 64;
  localparam int          UNLOCK_ERRORS = 4;
  localparam int          FLUSH_WORDS   = 8;

  localparam int PH_RESYNC = 0, PH_FLUSH = 1, PH_HUNT = 2, PH_LOCKED = 3;

  logic          clk;
  logic          rst;
  logic [DW-1:0] in_data;
  logic          in_valid;
  logic          resync;
  logic          err_in;
  logic          desc_rst;
  logic [DW-1:0] desc_data_in;
  logic          desc_data_in_valid;
  logic [DW-1:0] desc_data_out;
  logic          locked;
  logic          lock_lost;
  logic [15:0]   err_count;
  logic [1:0]    state_dbg;
  logic          err_tag;

  lfsr_descramble_sync #(
    .DATA_WIDTH(DW), .LFSR_WIDTH(58), .DESC_LATENCY(1), .IDLE_PATTERN(IDLE),
    .LOCK_COUNT(LOCK_COUNT), .HUNT_TIMEOUT(HUNT_TIMEOUT), .ERR_WINDOW(ERR_WINDOW),
    .UNLOCK_ERRORS(UNLOCK_ERRORS)
  ) dut (
    .clk(clk), .rst(rst), .in_data(in_data), .in_valid(in_valid), .resync(resync),
    .err_in(err_in), .desc_rst(desc_rst), .desc_data_in(desc_data_in),
    .desc_data_in_valid(desc_data_in_valid), .desc_data_out(desc_data_out),
    .locked(locked), .lock_lost(lock_lost), .err_count(err_count), .state_dbg(state_dbg)
  );

  // Clock / reset
  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Descrambler stub: identity with one cycle latency; the error tag travels with its word.
  always @(posedge clk) begin
    desc_data_out <= desc_data_in;
    err_in        <= err_tag & desc_data_in_valid;
  end

  int n_checks;
  int n_errors;
  bit mon_en;
  logic [19:0] exp_q[$];

  // Reference model state, in word-level terms
  int m_phase, m_rst_left, m_flush_left, m_run, m_hunt_words, m_win_pos, m_win_errs, m_total;
  bit m_desc_rst, m_locked, m_lost;
  bit p_valid, p_err;
  logic [7:0] p_data;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    m_phase = PH_RESYNC; m_rst_left = 2; m_flush_left = 0; m_run = 0; m_hunt_words = 0;
    m_win_pos = 0; m_win_errs = 0; m_total = 0;
    m_desc_rst = 1'b1; m_locked = 1'b0; m_lost = 1'b0;
    p_valid = 1'b0; p_err = 1'b0; p_data = '0;
  endtask

  task automatic model_edge(input bit v, input logic [7:0] d, input bit rs, input bit e);
    bit ov, oe, go_rs, was_lk;
    logic [7:0] od;
    ov = p_valid; od = p_data; oe = p_err;
    p_valid = v && !m_desc_rst;
    p_data  = d;
    p_err   = e && v && !m_desc_rst;
    go_rs   = 1'b0;
    was_lk  = (m_phase == PH_LOCKED);
    case (m_phase)
      PH_RESYNC: begin
        m_rst_left--;
        if (m_rst_left == 0) begin m_phase = PH_FLUSH; m_flush_left = FLUSH_WORDS; end
      end
      PH_FLUSH: if (ov) begin
        m_flush_left--;
        if (m_flush_left == 0) m_phase = PH_HUNT;
      end
      PH_HUNT: if (ov) begin
        m_hunt_words++;
        m_run = (od == IDLE) ? m_run + 1 : 0;
        if (m_run == LOCK_COUNT) begin
          m_phase = PH_LOCKED; m_win_pos = 0; m_win_errs = 0;
        end else if (m_hunt_words == HUNT_TIMEOUT) go_rs = 1'b1;
      end
      default: if (ov) begin
        if (oe && m_total < 65535) m_total++;
        if (m_win_pos == ERR_WINDOW - 1) begin
          m_win_pos = 0; m_win_errs = int'(oe);
        end else begin
          m_win_pos++; m_win_errs += int'(oe);
        end
        if (m_win_errs >= UNLOCK_ERRORS) go_rs = 1'b1;
      end
    endcase
    if (rs) go_rs = 1'b1;
    m_lost = go_rs && was_lk;
    if (go_rs) begin
      m_phase = PH_RESYNC; m_rst_left = 2; m_run = 0; m_hunt_words = 0;
      m_win_pos = 0; m_win_errs = 0;
    end
    m_desc_rst = (m_phase == PH_RESYNC);
    m_locked   = (m_phase == PH_LOCKED);
  endtask

  // Driver: called just after a rising edge; drives one cycle of inputs and queues the expected status.
  task automatic cycle(input bit v, input logic [7:0] d, input bit rs, input bit e);
    in_valid = v; in_data = d; resync = rs; err_tag = e;
    exp_q.push_back({m_desc_rst, m_locked, m_lost, 16'(m_total), v & ~m_desc_rst});
    model_edge(v, d, rs, e);
    @(posedge clk);
    #1;
  endtask

  task automatic wait_lock(input string name, input int max_calls);
    int k;
    k = 0;
    while (!locked && k < max_calls) begin
      cycle(1'b1, IDLE, 1'b0, 1'b0);
      k++;
    end
    check(name, int'(locked), 1);
  endtask

  // Scoreboard monitor
  always @(negedge clk) begin : monitor
    logic [19:0] act;
    logic [19:0] exp;
    if (mon_en) begin
      act = {desc_rst, locked, lock_lost, err_count, desc_data_in_valid};
      n_checks++;
      if (exp_q.size() == 0) begin
        n_errors++;
        $display("FAIL sb_underflow: got %h with no expected entry (t=%0t)", act, $time);
      end else begin
        exp = exp_q.pop_front();
        if (act !== exp) begin
          n_errors++;
          $display("FAIL sb_status: got %h expected %h {desc_rst,locked,lock_lost,err_count,dv} (t=%0t)",
                   act, exp, $time);
        end
      end
    end
  end

  initial begin
    int lost_cnt, dr_cnt, lock_seen;
    n_checks = 0; n_errors = 0; mon_en = 1'b0;
    rst = 1'b0; in_valid = 1'b0; in_data = '0; resync = 1'b0; err_tag = 1'b0;
    model_reset();

    // Reset values
    repeat (3) @(posedge clk);
    #1;
    check("rst_desc_rst", int'(desc_rst), 1);
    check("rst_locked", int'(locked), 0);
    check("rst_lock_lost", int'(lock_lost), 0);
    check("rst_err_count", int'(err_count), 0);
    in_valid = 1'b1;
    #1;
    check("rst_dv_masked", int'(desc_data_in_valid), 0);
    in_valid = 1'b0;
    @(posedge clk);
    #1;
    rst = 1'b1;
    mon_en = 1'b1;

    // Initial lock on idle words: 2 reset cycles, 8 flush, 16 matches, 1 latency
    cycle(1'b1, IDLE, 1'b0, 1'b0);
    check("desc_rst_cycle2", int'(desc_rst), 1);
    cycle(1'b1, IDLE, 1'b0, 1'b0);
    check("desc_rst_released", int'(desc_rst), 0);
    repeat (24) cycle(1'b1, IDLE, 1'b0, 1'b0);
    check("lock_not_early", int'(locked), 0);
    cycle(1'b1, IDLE, 1'b0, 1'b0);
    check("lock_time", int'(locked), 1);
    check("lock_err_count", int'(err_count), 0);

    // Resync from LOCKED, then a mismatch at match 15 during hunt
    cycle(1'b1, IDLE, 1'b1, 1'b0);
    check("resync_lock_lost", int'(lock_lost), 1);
    check("resync_unlocked", int'(locked), 0);
    repeat (2 + 8 + 15) cycle(1'b1, IDLE, 1'b0, 1'b0);
    cycle(1'b1, 8'h5A, 1'b0, 1'b0);
    repeat (16) cycle(1'b1, IDLE, 1'b0, 1'b0);
    check("relock_not_early", int'(locked), 0);
    cycle(1'b1, IDLE, 1'b0, 1'b0);
    check("relock_after_mismatch", int'(locked), 1);

    // Four errors inside one window
    lost_cnt = 0; dr_cnt = 0;
    for (int i = 0; i < 30; i++) begin
      cycle(1'b1, IDLE, 1'b0, (i == 4 || i == 9 || i == 14 || i == 19));
      lost_cnt += int'(lock_lost);
      dr_cnt   += int'(desc_rst);
    end
    check("unlock_pulses", lost_cnt, 1);
    check("unlock_locked", int'(locked), 0);
    check("unlock_err_count", int'(err_count), 4);
    check("unlock_desc_rst_cycles", dr_cnt, 2);

    // Hunt timeout: never-idle words force a second reset pulse
    cycle(1'b1, 8'($urandom_range(1, 255)), 1'b1, 1'b0);
    dr_cnt = 0; lock_seen = 0;
    for (int i = 1; i <= 1100; i++) begin
      cycle(1'b1, 8'($urandom_range(1, 255)), 1'b0, 1'b0);
      dr_cnt    += int'(desc_rst);
      lock_seen |= int'(locked);
    end
    check("timeout_desc_rst_cycles", dr_cnt, 3);
    check("timeout_no_lock", lock_seen, 0);

    // Asynchronous reset mid-operation
    mon_en = 1'b0;
    rst = 1'b0;
    #1;
    check("async_desc_rst", int'(desc_rst), 1);
    check("async_locked", int'(locked), 0);
    check("async_lock_lost", int'(lock_lost), 0);
    check("async_err_count", int'(err_count), 0);
    @(posedge clk);
    @(posedge clk);
    #1;
    model_reset();
    rst = 1'b1;
    mon_en = 1'b1;
    wait_lock("lock_after_async_reset", 100);

    // Ten windows with three errors each
    lost_cnt = 0;
    for (int j = 1; j <= 640; j++) begin
      cycle(1'b1, IDLE, 1'b0, (j % 64 == 10 || j % 64 == 30 || j % 64 == 50));
      lost_cnt += int'(lock_lost);
    end
    check("windows_locked", int'(locked), 1);
    check("windows_no_loss", lost_cnt, 0);
    check("windows_err_count", int'(err_count), 30);

    // resync coinciding with an error word in LOCKED
    cycle(1'b1, IDLE, 1'b0, 1'b1);
    cycle(1'b1, IDLE, 1'b1, 1'b0);
    check("resync_err_lock_lost", int'(lock_lost), 1);
    check("resync_err_locked", int'(locked), 0);
    check("resync_err_count", int'(err_count), 31);
    check("resync_err_desc_rst", int'(desc_rst), 1);

    // Randomised traffic
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 9) != 0),
            ($urandom_range(0, 29) == 0) ? 8'($urandom_range(1, 255)) : IDLE,
            ($urandom_range(0, 499) == 0),
            ($urandom_range(0, 24) == 0));
    end
    mon_en = 1'b0;
    check("sb_drain", exp_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
